// File: rtl/iomem_cmd_master.sv
// iomem_cmd_master
//   Byte-stream to iomem bus initiator. It parses fixed-format command frames
//   from a byte stream, issues one iomem transaction per frame, and streams
//   back the response bytes.
//     Write frame: 0x57, addr[4], strb[1], data[4]  (little-endian) -> 0x4B
//     Read frame : 0x52, addr[4]                    (little-endian) -> 0x4B + rdata[4]
//     Bad opcode -> 0x45 ('E'); bus timeout -> 0x54 ('T')
// Ports
//   CLKOUT, resetn         : clock, synchronous active-low reset
//   in_valid/ready/data    : command byte stream (sink)
//   out_valid/ready/data   : response byte stream (source)
//   iomem_*                : bus initiator side, one outstanding transaction
//   busy                   : high whenever the parser is not idle in OP
module iomem_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        CLKOUT,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata,
  output logic        busy
);
  typedef enum logic [2:0] {OP, ADDR, STRB, DATA, BUS, RESP} state_t;

  state_t           r_state;
  logic             r_is_wr;
  logic [1:0]       r_idx;     // byte index within addr/data field
  logic [CNT_W-1:0] r_cnt;     // bus wait counter
  logic [31:0]      r_rdata;
  logic [2:0]       r_ridx;    // index of response byte currently presented
  logic [2:0]       r_rlast;   // index of the final response byte

  logic             w_in_acc, w_out_acc, w_tmo;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_in_acc  = in_valid && in_ready;
  assign w_out_acc = out_valid && out_ready;
  assign w_cnt_nxt = r_cnt + 1'b1;
  // A zero limit disables the abort entirely.
  assign w_tmo     = (TIMEOUT_CYCLES != 0) && (w_cnt_nxt == CNT_W'(TIMEOUT_CYCLES));
  assign busy      = (r_state != OP);

  always_ff @(posedge CLKOUT) begin
    if (!resetn) begin
      r_state     <= OP;
      r_is_wr     <= 1'b0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_ridx      <= '0;
      r_rlast     <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_data    <= '0;
      iomem_valid <= 1'b0;
      iomem_wstrb <= '0;
      iomem_addr  <= '0;
      iomem_wdata <= '0;
    end else begin
      case (r_state)
        OP: if (w_in_acc) begin
          if (in_data == 8'h57 || in_data == 8'h52) begin
            r_is_wr <= (in_data == 8'h57);
            r_idx   <= '0;
            r_state <= ADDR;
          end else begin
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            out_data  <= 8'h45;
            r_ridx    <= '0;
            r_rlast   <= '0;
            r_state   <= RESP;
          end
        end
        ADDR: if (w_in_acc) begin
          iomem_addr[{r_idx, 3'b000} +: 8] <= in_data;
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            if (r_is_wr) begin
              r_state <= STRB;
            end else begin
              iomem_wstrb <= '0;
              in_ready    <= 1'b0;
              iomem_valid <= 1'b1;
              r_cnt       <= '0;
              r_state     <= BUS;
            end
          end
        end
        STRB: if (w_in_acc) begin
          iomem_wstrb <= in_data[3:0];
          r_idx       <= '0;
          r_state     <= DATA;
        end
        DATA: if (w_in_acc) begin
          iomem_wdata[{r_idx, 3'b000} +: 8] <= in_data;
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            in_ready    <= 1'b0;
            iomem_valid <= 1'b1;
            r_cnt       <= '0;
            r_state     <= BUS;
          end
        end
        BUS: begin
          // Ready wins over a timeout landing in the same cycle.
          if (iomem_ready) begin
            iomem_valid <= 1'b0;
            r_rdata     <= iomem_rdata;
            out_valid   <= 1'b1;
            out_data    <= 8'h4B;
            r_ridx      <= '0;
            r_rlast     <= r_is_wr ? 3'd0 : 3'd4;
            r_state     <= RESP;
          end else if (w_tmo) begin
            iomem_valid <= 1'b0;
            out_valid   <= 1'b1;
            out_data    <= 8'h54;
            r_ridx      <= '0;
            r_rlast     <= '0;
            r_state     <= RESP;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        RESP: if (w_out_acc) begin
          if (r_ridx == r_rlast) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= OP;
          end else begin
            // Byte 0 is the 'K'; byte k (k>=1) is rdata byte k-1.
            out_data <= r_rdata[{r_ridx[1:0], 3'b000} +: 8];
            r_ridx   <= r_ridx + 3'd1;
          end
        end
        default: r_state <= OP;
      endcase
    end
  end
endmodule

// File: tb/tb_iomem_cmd_master.sv
// Scoreboard bench for iomem_cmd_master: stimulus pushes expected bus
// transactions and response bytes; independent monitors pop and compare.
module tb_iomem_cmd_master;
  localparam int TMO = 8;

  logic        CLKOUT = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [7:0]  in_data = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        iomem_valid, iomem_ready = 1'b0;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr, iomem_wdata, iomem_rdata = '0;
  logic        busy;

  always #5 CLKOUT = ~CLKOUT;

  iomem_cmd_master #(.TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
    .CLKOUT(CLKOUT), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .busy(busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    bit          chk_wdata;
    int          len;   // expected valid-high cycles, -1 = unchecked
  } txn_t;

  txn_t        bus_q[$];
  logic [7:0]  out_q[$];
  int          n_cmp = 0, n_bad = 0;
  bit          resp_en = 1'b1, hold = 1'b0;
  int          resp_lat = 0;
  logic [31:0] next_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus responder: ready after resp_lat wait cycles, only while enabled.
  initial begin
    int lc;
    lc = 0;
    forever begin
      @(posedge CLKOUT); #1;
      if (resp_en) begin
        iomem_ready = 1'b0;
        if (iomem_valid) begin
          if (lc >= resp_lat) begin
            iomem_ready = 1'b1;
            iomem_rdata = next_rdata;
            lc = 0;
          end else lc++;
        end else lc = 0;
      end
    end
  end

  // Random output backpressure.
  initial forever begin
    @(posedge CLKOUT); #1;
    out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Output monitor.
  initial begin
    bit         ph;
    logic [7:0] pd;
    ph = 1'b0; pd = '0;
    forever begin
      @(negedge CLKOUT);
      if (ph) begin
        chk("out_hold_valid", 32'(out_valid), 32'd1);
        chk("out_hold_data", 32'(out_data), 32'(pd));
      end
      if (out_valid && out_ready) begin
        if (out_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_out: got %h expected no byte", out_data);
        end else chk("out_byte", 32'(out_data), 32'(out_q.pop_front()));
      end
      ph = out_valid && !out_ready;
      pd = out_data;
    end
  end

  // Bus monitor.
  initial begin
    bit          pv;
    txn_t        cur;
    int          len;
    logic [31:0] a, d;
    logic [3:0]  s;
    pv = 1'b0; len = 0; a = '0; d = '0; s = '0;
    cur.len = -1;
    forever begin
      @(negedge CLKOUT);
      if (iomem_valid) begin
        chk("busy_in_bus", 32'(busy), 32'd1);
        chk("in_ready_in_bus", 32'(in_ready), 32'd0);
        if (!pv) begin
          len = 0; a = iomem_addr; s = iomem_wstrb; d = iomem_wdata;
          if (bus_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_bus: got addr %h expected no bus cycle", iomem_addr);
            cur.len = -1;
          end else begin
            cur = bus_q.pop_front();
            chk("bus_addr", iomem_addr, cur.addr);
            chk("bus_wstrb", 32'(iomem_wstrb), 32'(cur.wstrb));
            if (cur.chk_wdata) chk("bus_wdata", iomem_wdata, cur.wdata);
          end
        end else begin
          chk("addr_stable", iomem_addr, a);
          chk("wstrb_stable", 32'(iomem_wstrb), 32'(s));
          chk("wdata_stable", iomem_wdata, d);
        end
        len++;
      end else if (pv && cur.len >= 0) begin
        chk("valid_len", 32'(len), 32'(cur.len));
      end
      pv = iomem_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int w;
    repeat (gap) @(negedge CLKOUT);
    w = 0;
    while (!in_ready && w < 100) begin @(negedge CLKOUT); w++; end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL in_ready_wait: got 0 expected 1");
    end
    in_valid = 1'b1; in_data = b;
    @(posedge CLKOUT); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_write_bytes(input logic [31:0] a, input logic [7:0] sb,
                                  input logic [31:0] d, input int gm, input int nb);
    logic [7:0] fr [10];
    fr[0] = 8'h57;
    for (int i = 0; i < 4; i++) fr[1+i] = a[8*i +: 8];
    fr[5] = sb;
    for (int i = 0; i < 4; i++) fr[6+i] = d[8*i +: 8];
    for (int i = 0; i < nb; i++) send_byte(fr[i], $urandom_range(0, gm));
  endtask

  task automatic do_write(input logic [31:0] a, input logic [7:0] sb,
                          input logic [31:0] d, input int gm);
    txn_t t;
    t.addr = a; t.wstrb = sb[3:0]; t.wdata = d; t.chk_wdata = 1'b1; t.len = resp_lat + 1;
    bus_q.push_back(t);
    out_q.push_back(8'h4B);
    send_write_bytes(a, sb, d, gm, 10);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] rd, input int gm,
                         input int len, input bit ok, input bit push_out);
    txn_t t;
    t.addr = a; t.wstrb = 4'h0; t.wdata = '0; t.chk_wdata = 1'b0; t.len = len;
    bus_q.push_back(t);
    next_rdata = rd;
    if (push_out) begin
      if (ok) begin
        out_q.push_back(8'h4B);
        for (int i = 0; i < 4; i++) out_q.push_back(rd[8*i +: 8]);
      end else out_q.push_back(8'h54);
    end
    send_byte(8'h52, $urandom_range(0, gm));
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], $urandom_range(0, gm));
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    @(negedge CLKOUT);
    while (!(out_q.size() == 0 && bus_q.size() == 0 && in_ready && !out_valid &&
             !iomem_valid && !busy) && w < 300) begin
      @(negedge CLKOUT); w++;
    end
    n_cmp++;
    if (w >= 300) begin
      n_bad++;
      $display("FAIL idle_wait: got busy after %0d cycles expected idle", w);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_iomem_valid", 32'(iomem_valid), 32'd0);
    chk("rst_wstrb", 32'(iomem_wstrb), 32'd0);
    chk("rst_addr", iomem_addr, 32'd0);
    chk("rst_wdata", iomem_wdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int w;
    logic [7:0] b;
    repeat (3) @(negedge CLKOUT);
    check_reset_vals();
    resetn = 1'b1;

    // Basic write, 1-cycle responder.
    resp_lat = 0;
    do_write(32'h0300_0000, 8'h0F, 32'h0000_1234, 0);
    wait_idle();

    // Read with held-off output.
    resp_lat = 2;
    hold = 1'b1;
    do_read(32'h0300_0000, 32'hA5A5_5A5A, 0, 3, 1'b1, 1'b1);
    w = 0;
    while (!out_valid && w < 50) begin @(negedge CLKOUT); w++; end
    repeat (5) @(negedge CLKOUT);
    hold = 1'b0;
    wait_idle();

    // Bad opcode, then a normal frame.
    out_q.push_back(8'h45);
    send_byte(8'h00, 0);
    wait_idle();
    resp_lat = 1;
    do_write(32'h0300_0004, 8'h01, 32'hDEAD_BEEF, 1);
    wait_idle();

    // Timeout, then an ignored late ready.
    resp_en = 1'b0;
    iomem_ready = 1'b0;
    do_read(32'h0300_0008, 32'h0, 0, TMO, 1'b0, 1'b1);
    wait_idle();
    @(posedge CLKOUT); #1;
    iomem_ready = 1'b1; iomem_rdata = $urandom;
    @(posedge CLKOUT); #1;
    iomem_ready = 1'b0;
    repeat (4) @(negedge CLKOUT);
    chk("late_rdy_in_ready", 32'(in_ready), 32'd1);
    chk("late_rdy_busy", 32'(busy), 32'd0);
    resp_en = 1'b1;

    // Reset after 6 bytes of a write frame.
    send_write_bytes(32'h1122_3344, 8'h0F, 32'h5566_7788, 0, 6);
    @(negedge CLKOUT); resetn = 1'b0;
    @(negedge CLKOUT); check_reset_vals(); resetn = 1'b1;
    resp_lat = 0;
    do_write(32'h0300_0010, 8'h0C, 32'hCAFE_F00D, 0);
    wait_idle();

    // Reset mid bus cycle.
    resp_en = 1'b0;
    do_read(32'h0300_0020, 32'h0, 0, -1, 1'b0, 1'b0);
    w = 0;
    while (!iomem_valid && w < 50) begin @(negedge CLKOUT); w++; end
    repeat (2) @(negedge CLKOUT);
    resetn = 1'b0;
    @(negedge CLKOUT); check_reset_vals(); resetn = 1'b1;
    resp_en = 1'b1;
    resp_lat = 3;
    do_read(32'h0300_0024, 32'h0102_0304, 0, 4, 1'b1, 1'b1);
    wait_idle();

    // strb=0x03 with random input gaps; strb=0 write.
    resp_lat = 1;
    do_write(32'h0300_0030, 8'h03, 32'h89AB_CDEF, 3);
    wait_idle();
    do_write(32'h0300_0034, 8'h00, 32'h1357_9BDF, 0);
    wait_idle();

    // Randomized mix.
    for (int it = 0; it < 30; it++) begin
      int k;
      k = $urandom_range(0, 9);
      resp_lat = $urandom_range(0, 5);
      if (k == 0) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h57 || b == 8'h52) b = 8'hFF;
        out_q.push_back(8'h45);
        send_byte(b, $urandom_range(0, 2));
      end else if (k < 5) begin
        do_write($urandom, 8'($urandom_range(0, 255)), $urandom, 2);
      end else begin
        do_read($urandom, $urandom, 2, resp_lat + 1, 1'b1, 1'b1);
      end
      wait_idle();
    end

    chk("bus_q_empty", 32'(bus_q.size()), 32'd0);
    chk("out_q_empty", 32'(out_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/iomem_cmd_master.md
Name: iomem_cmd_master

Overview:
- Byte-stream-to-iomem bus initiator: parses fixed-format read/write command frames from a byte stream, issues one iomem transaction per frame, and returns response bytes on an output stream.
- Sits between a UART byte interface and the SoC iomem port as a debug/host access path, driving peripherals such as the GPIO/LED responder at 0x03xx_xxxx.

Parameters:
- TIMEOUT_CYCLES, 255: cycles iomem_valid may stay high without iomem_ready before aborting; 0 disables the timeout.
- CNT_W, 16: timeout counter width; TIMEOUT_CYCLES < 2**CNT_W.

Ports:
- CLKOUT  in  1  clock, all logic on posedge.
- resetn  in  1  synchronous, active-low reset.
- in_valid  in  1  command byte valid.
- in_ready  out  1  command byte accepted when in_valid && in_ready at posedge.
- in_data  in  8  command byte.
- out_valid  out  1  response byte valid.
- out_ready  in  1  response byte consumed when out_valid && out_ready at posedge.
- out_data  out  8  response byte.
- iomem_valid  out  1  bus request.
- iomem_ready  in  1  responder completion strobe.
- iomem_wstrb  out  4  byte write enables; 0 means read.
- iomem_addr  out  32  bus address.
- iomem_wdata  out  32  write data.
- iomem_rdata  in  32  read data, valid in the cycle iomem_ready=1.
- busy  out  1  high in any state other than OP.

Behaviour:
- Reset (resetn=0 at posedge), from any state including mid-frame or mid-bus-cycle:
  - state=OP; in_ready=1; out_valid=0; out_data=0; iomem_valid=0; iomem_wstrb=0; iomem_addr=0; iomem_wdata=0; busy=0; counters cleared.
  - Partial frames are discarded.
- Frame formats, multi-byte fields little-endian:
  - Write: 0x57, addr[4], strb[1] (low 4 bits used), data[4]; 10 bytes.
  - Read: 0x52, addr[4]; 5 bytes.
- States: OP, ADDR, STRB, DATA, BUS, RESP.
- OP (in_ready=1): byte 0x57 or 0x52 is latched as the opcode -> ADDR. Any other byte -> RESP with the single byte 0x45 ('E'); no bus cycle.
- ADDR (in_ready=1): 4 bytes shift into iomem_addr, LSB first, using a 2-bit index. After the 4th byte: write -> STRB; read -> BUS with wstrb=0.
- STRB (in_ready=1): 1 byte; iomem_wstrb <= in_data[3:0] -> DATA.
- DATA (in_ready=1): 4 bytes into iomem_wdata, LSB first -> BUS.
- in_ready is a registered output: 0 in BUS and RESP, 1 elsewhere.
- BUS:
  - iomem_valid=1 starting the cycle after the last frame byte is accepted.
  - addr, wdata and wstrb stay stable while iomem_valid=1.
  - iomem_ready=1 sampled at posedge: iomem_valid<=0 at that edge (exactly one ready observed per transaction). Read data is latched from iomem_rdata at the same edge. Go to RESP.
  - The timeout counter increments each BUS cycle with iomem_ready=0. When it equals TIMEOUT_CYCLES (nonzero): iomem_valid<=0, RESP with the single byte 0x54 ('T').
  - iomem_ready arriving in the same cycle the counter hits the limit counts as success.
  - iomem_ready while not in BUS is ignored.
- RESP:
  - out_valid=1 starting the cycle after entry; out_data stays stable until accepted.
  - Responses: write success -> 0x4B. Read success -> 0x4B, then rdata[7:0], [15:8], [23:16], [31:24].
  - A write with strb=0 is still issued and answered 0x4B only.
  - Each accepted byte advances to the next byte the following cycle. After the last byte is accepted: out_valid<=0, in_ready<=1, state=OP.
- No pipelining: at most one outstanding transaction; commands are not accepted during BUS/RESP.

Test Plan:
- Write 57 00 00 00 03 0F 34 12 00 00 with a 1-cycle-latency responder -> one iomem_valid pulse with addr=0x03000000, wstrb=0xF, wdata=0x00001234; valid drops the edge ready is seen; output stream 0x4B; in_ready returns to 1.
- Read 52 00 00 00 03; responder returns rdata=0xA5A55A5A after 3 cycles -> wstrb=0; output 4B 5A 5A A5 A5. With out_ready held low for 5 cycles, out_data is unchanged throughout.
- Byte 0x00 in OP -> output 0x45 only; iomem_valid never asserted; next frame is processed normally.
- TIMEOUT_CYCLES=8, read with iomem_ready held low -> iomem_valid high exactly 8 cycles, then output 0x54. A late iomem_ready pulse afterwards causes no output and no state change.
- resetn low for 1 cycle after 6 bytes of a write frame, and again while iomem_valid=1 -> all outputs at reset values the next cycle; a fresh full frame then completes correctly.
- Write frame with strb=0x03 delivered with random in_valid gaps -> wstrb=0x3, addr and wdata assembled correctly; response 0x4B.
